// File: rtl/regfile_dump_reader.sv
// regfile_dump_reader: walks a register bank word by word and streams each word
// out LSB byte first over a valid/ready byte interface.
module regfile_dump_reader #(
  parameter int NB_REG  = 32,
  parameter int N_REGS  = 32,
  parameter int NB_ADDR = 5,
  parameter int NB_BYTE = 8
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic               i_start,
  output logic [NB_ADDR-1:0] o_rd_addr,
  input  logic [NB_REG-1:0]  i_rd_data,
  output logic [NB_BYTE-1:0] o_tx_data,
  output logic               o_tx_valid,
  input  logic               i_tx_ready,
  output logic               o_busy,
  output logic               o_done
);
  localparam int N_BYTES = NB_REG / NB_BYTE;
  localparam int NB_CNT  = $clog2(N_BYTES + 1);
  typedef enum logic [2:0] {IDLE, READ, LATCH, SEND, DONE} state_t;
  state_t             state;
  logic [NB_CNT-1:0]  cnt;
  logic [NB_REG-1:0]  shift;
  // o_rd_addr doubles as the register index; the outgoing byte is the low byte of the shifter
  assign o_tx_data = shift[NB_BYTE-1:0];
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state      <= IDLE;
      cnt        <= '0;
      shift      <= '0;
      o_rd_addr  <= '0;
      o_tx_valid <= 1'b0;
      o_busy     <= 1'b0;
      o_done     <= 1'b0;
    end else begin
      o_done <= 1'b0;
      case (state)
        IDLE: if (i_start) begin
          o_rd_addr <= '0;
          o_busy    <= 1'b1;
          state     <= READ;
        end
        READ: state <= LATCH;
        LATCH: begin
          shift      <= i_rd_data;
          cnt        <= '0;
          o_tx_valid <= 1'b1;
          state      <= SEND;
        end
        SEND: if (o_tx_valid && i_tx_ready) begin
          shift <= shift >> NB_BYTE;
          cnt   <= cnt + NB_CNT'(1);
          if (cnt == NB_CNT'(N_BYTES - 1)) begin
            o_tx_valid <= 1'b0;
            if (o_rd_addr == NB_ADDR'(N_REGS - 1)) begin
              o_done <= 1'b1;
              state  <= DONE;
            end else begin
              o_rd_addr <= o_rd_addr + NB_ADDR'(1);
              state     <= READ;
            end
          end
        end
        DONE: begin
          o_busy <= 1'b0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
